sample_loader: RTL and testbench
================================

SAMPLE_LOADER -- requirements
Module: sample_loader

Interface
REQ-001 Parameter: WIDTH, 8, bit width of one sample.
REQ-002 Parameter: DEPTH, 32, samples per batch; supported values are powers of two from 2 to 32.
REQ-003 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-low.
REQ-005 Port: in_valid  input  1  upstream sample strobe.
REQ-006 Port: in_data  input  WIDTH  upstream sample value.
REQ-007 Port: in_ready  output  1  loader accepts a sample this cycle.
REQ-008 Port: clear  input  1  synchronous batch abort.
REQ-009 Port: calc_ready  input  1  the downstream mean unit is idle.
REQ-010 Port: calc_done  input  1  the downstream mean unit has finished and its result is valid.
REQ-011 Port: ROM  output  array [1:DEPTH] of WIDTH  sample buffer presented to the mean unit, with entry 1 holding the first sample.
REQ-012 Port: start  output  1  launch pulse to the mean unit.
REQ-013 Port: count  output  6  number of samples stored in the current batch.
REQ-014 Port: batches  output  8  number of completed batches, wrapping modulo 256.

Function
REQ-015 The block SHALL implement three states: FILL, LAUNCH and WAIT.
REQ-016 In FILL, in_ready SHALL be 1; in LAUNCH and WAIT, in_ready SHALL be 0.
REQ-017 A transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; it SHALL write in_data to ROM[count+1] and increment count by 1.
REQ-018 When in_valid=0 in FILL, the block SHALL hold count and ROM unchanged.
REQ-019 On the transfer that makes count equal to DEPTH, the block SHALL move to LAUNCH on the same edge; a further sample offered in that cycle SHALL NOT be accepted.
REQ-020 In LAUNCH, start SHALL remain 0 until calc_ready=1.
REQ-021 Once calc_ready=1 is sampled in LAUNCH, start SHALL be 1 for exactly 2 consecutive cycles; after those 2 cycles the block SHALL move to WAIT.
REQ-022 start SHALL be a registered output and SHALL be 0 in FILL and WAIT.
REQ-023 In WAIT, the block SHALL hold ROM stable until calc_done=1 is sampled.
REQ-024 When calc_done=1 is sampled in WAIT, the block SHALL on that edge set count to 0, increment batches (255 wraps to 0) and move to FILL; in_ready SHALL be 1 from the next cycle.
REQ-025 calc_done sampled in FILL or LAUNCH SHALL be ignored.
REQ-026 clear=1 SHALL, on the next edge and in any state, set count to 0, set start to 0 and move to FILL.
REQ-027 clear SHALL NOT change ROM contents or batches.
REQ-028 clear SHALL have priority over a simultaneous transfer, and no sample SHALL be written in that cycle.
REQ-029 clear SHALL have priority over a simultaneous calc_done, and batches SHALL NOT increment in that cycle.
REQ-030 ROM entries above count SHALL keep their values from the previous batch until overwritten.

Reset
REQ-031 When rst=0, the block SHALL asynchronously enter FILL and set count=0, batches=0, start=0, every ROM entry to 0 and in_ready=1.
REQ-032 Reset asserted mid-batch or mid-pulse SHALL abort immediately with no further start cycle; reset deassertion SHALL take effect on the next rising edge.

Verification
REQ-033 Fill: pulse rst low, then stream 32 samples with in_valid held high, values 0..31 -> ROM[i]=i-1, count=32, in_ready=0 on the cycle after the 32nd transfer.
REQ-034 Launch: calc_ready=0 for 5 cycles, then 1 -> start=0 during the 5 cycles, then start=1 for exactly 2 cycles, then the block is in WAIT.
REQ-035 Completion: assert calc_done for 1 cycle in WAIT -> count=0, batches=1, in_ready=1 on the next cycle; a second batch of 32 values, each 8'hFF, overwrites every entry.
REQ-036 Gapped input: in_valid toggling 1,0,1,0 for 64 cycles -> exactly 32 transfers, with ROM order matching the offered order.
REQ-037 Abort: assert clear with in_valid=1 at count=10 -> count=0, ROM[11] unchanged, batches unchanged, and the next sample is written to ROM[1].
REQ-038 Reset mid-pulse: drive rst=0 during the first start cycle -> start=0 immediately, count=0 and every ROM entry = 0.

Source files
------------

// File: rtl/sample_loader.sv
// sample_loader: collects DEPTH samples into a buffer, then hands the full
// buffer to a downstream mean unit with a two-cycle start pulse and waits
// for it to finish before accepting the next batch.
module sample_loader #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [WIDTH-1:0]            in_data,
    output logic                        in_ready,
    input  logic                        clear,
    input  logic                        calc_ready,
    input  logic                        calc_done,
    output logic [1:DEPTH][WIDTH-1:0]   ROM,
    output logic                        start,
    output logic [5:0]                  count,
    output logic [7:0]                  batches
);

    localparam logic [1:0] S_FILL   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;

    logic [1:0] state;
    logic       pulse_tail;   // set while start is in its second cycle
    logic       xfer;

    assign in_ready = (state == S_FILL);
    // clear wins over a same-cycle transfer, so no write happens then
    assign xfer     = in_ready && in_valid && !clear;

    // Control: fill counting, launch pulse sequencing, completion handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_FILL;
            count      <= '0;
            batches    <= '0;
            start      <= 1'b0;
            pulse_tail <= 1'b0;
        end else if (clear) begin
            state      <= S_FILL;
            count      <= '0;
            start      <= 1'b0;
            pulse_tail <= 1'b0;
        end else begin
            case (state)
                S_FILL: begin
                    if (in_valid) begin
                        count <= count + 6'd1;
                        if (count == 6'(DEPTH - 1))
                            state <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    if (start) begin
                        if (pulse_tail) begin
                            start      <= 1'b0;
                            pulse_tail <= 1'b0;
                            state      <= S_WAIT;
                        end else begin
                            pulse_tail <= 1'b1;
                        end
                    end else if (calc_ready) begin
                        start <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (calc_done) begin
                        count   <= '0;
                        batches <= batches + 8'd1;
                        state   <= S_FILL;
                    end
                end
                default: state <= S_FILL;
            endcase
        end
    end

    // Sample buffer: entry count+1 takes the accepted sample; other entries
    // keep whatever the previous batch left there
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ROM <= '0;
        end else begin
            for (int i = 1; i <= DEPTH; i++) begin
                if (xfer && (count == 6'(i - 1)))
                    ROM[i] <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_sample_loader.sv
// Directed bench for sample_loader: fill, launch, completion, gapped input,
// abort via clear, and reset during the start pulse.
module tb_sample_loader;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic             clear;
    logic             calc_ready;
    logic             calc_done;
    logic [1:32][7:0] rom_q;
    logic             start;
    logic [5:0]       count;
    logic [7:0]       batches;

    int checks = 0;
    int errors = 0;

    sample_loader #(.WIDTH(8), .DEPTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .clear(clear), .calc_ready(calc_ready),
        .calc_done(calc_done), .ROM(rom_q), .start(start),
        .count(count), .batches(batches)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one rising edge, then settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = '0; clear = 1'b0;
        calc_ready = 1'b0; calc_done = 1'b0;
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_batches", 32'(batches), 0);
        chk("rst_start", 32'(start), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_rom1", 32'(rom_q[1]), 0);
        tick(); tick();
        rst = 1'b1;
        tick();

        // Fill 0..31 back-to-back, then offer one extra that must be refused
        in_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            in_data = 8'(i);
            tick();
        end
        chk("fill_count", 32'(count), 32);
        chk("fill_in_ready", 32'(in_ready), 0);
        in_data = 8'h99;
        tick();
        chk("fill_extra_count", 32'(count), 32);
        in_valid = 1'b0;
        for (int i = 1; i <= 32; i++) chk("fill_rom", 32'(rom_q[i]), 32'(i - 1));

        // Launch held off by calc_ready, then exactly two start cycles
        calc_done = 1'b1;   // ignored outside WAIT
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("launch_hold_start", 32'(start), 0);
        end
        chk("launch_done_ignored", 32'(batches), 0);
        calc_done = 1'b0;
        calc_ready = 1'b1;
        tick(); chk("launch_start1", 32'(start), 1);
        tick(); chk("launch_start2", 32'(start), 1);
        tick(); chk("launch_start_end", 32'(start), 0);
        chk("wait_in_ready", 32'(in_ready), 0);
        tick(); tick();
        chk("wait_no_restart", 32'(start), 0);
        chk("wait_rom_stable", 32'(rom_q[5]), 4);

        // Completion, then second batch of all-ones
        calc_done = 1'b1;
        tick();
        calc_done = 1'b0;
        chk("done_count", 32'(count), 0);
        chk("done_batches", 32'(batches), 1);
        chk("done_in_ready", 32'(in_ready), 1);
        in_valid = 1'b1; in_data = 8'hFF;
        for (int i = 0; i < 32; i++) tick();
        in_valid = 1'b0;
        for (int i = 1; i <= 32; i++) chk("batch2_rom", 32'(rom_q[i]), 32'hFF);
        tick(); tick(); tick();   // calc_ready still 1: two start cycles then WAIT
        calc_done = 1'b1;
        tick();
        calc_done = 1'b0;
        chk("batch2_batches", 32'(batches), 2);

        // Gapped input: valid on even cycles only, data 0x40 + k/2
        calc_ready = 1'b0;
        calc_done  = 1'b1;   // ignored in FILL
        for (int k = 0; k < 64; k++) begin
            in_valid = (k % 2 == 0);
            in_data  = 8'(8'h40 + k / 2);
            tick();
        end
        in_valid = 1'b0; calc_done = 1'b0;
        chk("gap_count", 32'(count), 32);
        chk("gap_batches", 32'(batches), 2);
        for (int i = 1; i <= 32; i++) chk("gap_rom", 32'(rom_q[i]), 32'(8'h40 + i - 1));
        calc_ready = 1'b1;
        tick(); tick(); tick();
        calc_done = 1'b1;
        tick();
        calc_done = 1'b0;
        chk("gap_done_batches", 32'(batches), 3);

        // Abort at count=10 with a sample offered
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 8'(8'hA0 + i);
            tick();
        end
        chk("abort_pre_count", 32'(count), 10);
        clear = 1'b1; in_data = 8'hEE;
        tick();
        clear = 1'b0;
        chk("abort_count", 32'(count), 0);
        chk("abort_rom11", 32'(rom_q[11]), 32'h4A);
        chk("abort_batches", 32'(batches), 3);
        chk("abort_in_ready", 32'(in_ready), 1);
        in_data = 8'h77;
        tick();
        in_valid = 1'b0;
        chk("abort_next_rom1", 32'(rom_q[1]), 32'h77);
        chk("abort_next_count", 32'(count), 1);
        chk("abort_rom2_kept", 32'(rom_q[2]), 32'hA1);

        // clear beats a simultaneous calc_done in WAIT
        in_valid = 1'b1; in_data = 8'h33;
        for (int i = 0; i < 31; i++) tick();
        in_valid = 1'b0;
        chk("clr_done_full", 32'(count), 32);
        tick(); tick(); tick();   // start pulse, then WAIT
        clear = 1'b1; calc_done = 1'b1;
        tick();
        clear = 1'b0; calc_done = 1'b0;
        chk("clr_done_batches", 32'(batches), 3);
        chk("clr_done_count", 32'(count), 0);
        chk("clr_done_in_ready", 32'(in_ready), 1);

        // Reset during the first start cycle
        calc_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h5A;
        for (int i = 0; i < 32; i++) tick();
        in_valid = 1'b0;
        calc_ready = 1'b1;
        tick();
        chk("rstmid_start_pre", 32'(start), 1);
        rst = 1'b0;
        #1;
        chk("rstmid_start", 32'(start), 0);
        chk("rstmid_count", 32'(count), 0);
        chk("rstmid_in_ready", 32'(in_ready), 1);
        for (int i = 1; i <= 32; i++) chk("rstmid_rom", 32'(rom_q[i]), 0);
        tick();
        chk("rstmid_start_held", 32'(start), 0);
        rst = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
